instruction_sequencer: RTL

- Instruction buffer and program sequencer sitting directly upstream of the TPU control unit.
- Host loads a program of 24-bit instruction words while idle; on start, the block issues one word per cycle on instr_out, which feeds the control unit's instruction input.
- Supports downstream stall (issues NOPs while stalled), abort, and a done pulse.
- NOP is all-zero: no load, no start, no switch.

---
 rtl/instruction_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// Instruction buffer and program sequencer feeding the TPU control unit.
// Host loads words while idle; on start the program is issued one word per cycle.
module instruction_sequencer #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned INSTR_WIDTH = 24,
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   wr_ready,
    input  logic                   clear,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   abort,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       prog_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       prog_count_q, prog_count_d;
    logic [CNT_W-1:0]       pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_out_q, instr_out_d;
    logic                   instr_valid_q, instr_valid_d;
    logic                   done_q, done_d;
    logic                   mem_we;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    assign wr_ready    = (state_q == StIdle) && (prog_count_q < DEPTH_C);
    assign busy        = (state_q == StRun);
    assign instr_out   = instr_out_q;
    assign instr_valid = instr_valid_q;
    assign done        = done_q;
    assign prog_count  = prog_count_q;

    always_comb begin
        state_d       = state_q;
        prog_count_d  = prog_count_q;
        pc_d          = pc_q;
        instr_out_d   = '0;
        instr_valid_d = 1'b0;
        done_d        = 1'b0;
        mem_we        = 1'b0;
        unique case (state_q)
            StIdle: begin
                // start outranks clear/write; an empty program completes immediately
                if (start) begin
                    if (prog_count_q != '0) begin
                        state_d       = StRun;
                        instr_out_d   = mem[AW'(0)];
                        instr_valid_d = 1'b1;
                        pc_d          = CNT_W'(1);
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (clear) begin
                    prog_count_d = '0;
                end else if (wr_en && wr_ready) begin
                    mem_we       = 1'b1;
                    prog_count_d = prog_count_q + CNT_W'(1);
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    pc_d    = '0;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (pc_q == prog_count_q) begin
                    state_d = StIdle;
                    pc_d    = '0;
                    done_d  = 1'b1;
                end else begin
                    instr_out_d   = mem[pc_q[AW-1:0]];
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            prog_count_q  <= '0;
            pc_q          <= '0;
            instr_out_q   <= '0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            prog_count_q  <= prog_count_d;
            pc_q          <= pc_d;
            instr_out_q   <= instr_out_d;
            instr_valid_q <= instr_valid_d;
            done_q        <= done_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[prog_count_q[AW-1:0]] <= wr_data;
        end
    end

endmodule
